// File: rtl/button_pkg.sv
// Shared state type, default timings and counter-sizing helpers for the
// button debouncer array and its per-channel logic.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } btn_state_t;

  localparam int DEF_NUM_BUTTONS        = 4;
  localparam int DEF_DEBOUNCE_CLKS      = 1000000;
  localparam int DEF_HOLD_DELAY_CLKS    = 25000000;
  localparam int DEF_REPEAT_PERIOD_CLKS = 5000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to represent every value in 0..max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

  function automatic bit params_valid(input int n, input int d, input int h, input int r);
    return (n >= 1) && (d >= 1) && (h >= 1) && (r >= 1);
  endfunction

endpackage

// File: rtl/button_debouncer_channel.sv
// One button channel: two-flop synchroniser, debounce counter, press/release
// edge pulses and a hold/auto-repeat state machine.
module button_debouncer_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH_IN_CLOCKS = DEF_DEBOUNCE_CLKS,
  parameter int HOLD_DELAY_CLOCKS        = DEF_HOLD_DELAY_CLKS,
  parameter int REPEAT_PERIOD_CLOCKS     = DEF_REPEAT_PERIOD_CLKS
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  input  logic repeat_en,
  output logic debounced_button,
  output logic pressed,
  output logic released,
  output logic repeat_tick
);

  localparam int DEB_W  = cnt_width(DEBOUNCE_WIDTH_IN_CLOCKS);
  localparam int HOLD_W = cnt_width(max_int(HOLD_DELAY_CLOCKS, REPEAT_PERIOD_CLOCKS));
  localparam logic [DEB_W-1:0]  DEB_MAX   = DEB_W'(DEBOUNCE_WIDTH_IN_CLOCKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_DELAY_CLOCKS - 1);
  localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_PERIOD_CLOCKS - 1);

  logic              sync_p0, sync_p1;
  logic [DEB_W-1:0]  deb_cnt;
  logic              toggle, rise, fall;
  btn_state_t        state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic              tick_nxt;

  // Stage p0/p1: metastability synchroniser on the raw button level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= button;
      sync_p1 <= sync_p0;
    end
  end

  assign toggle = (deb_cnt == DEB_MAX);
  assign rise   = toggle & ~debounced_button;
  assign fall   = toggle & debounced_button;

  // Debounce stage: a full run of mismatching samples flips the level
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt          <= '0;
      debounced_button <= 1'b0;
      pressed          <= 1'b0;
      released         <= 1'b0;
    end else begin
      pressed  <= rise;
      released <= fall;
      if (toggle) begin
        debounced_button <= ~debounced_button;
        deb_cnt          <= '0;
      end else if (sync_p1 != debounced_button) begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  // Repeat stage: state, hold counter and registered tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RELEASED;
      hold_cnt    <= '0;
      repeat_tick <= 1'b0;
    end else begin
      state       <= state_nxt;
      hold_cnt    <= hold_cnt_nxt;
      repeat_tick <= tick_nxt;
    end
  end

  // A debounced edge overrides any tick that would otherwise fall due
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    tick_nxt     = 1'b0;
    if (fall) begin
      state_nxt    = RELEASED;
      hold_cnt_nxt = '0;
    end else if (rise) begin
      state_nxt    = PRESSED;
      hold_cnt_nxt = '0;
    end else begin
      case (state)
        RELEASED: hold_cnt_nxt = '0;
        PRESSED: begin
          if (!repeat_en) begin
            hold_cnt_nxt = '0;
          end else if (hold_cnt == HOLD_LAST) begin
            tick_nxt     = 1'b1;
            state_nxt    = REPEATING;
            hold_cnt_nxt = '0;
          end else begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        REPEATING: begin
          if (!repeat_en) begin
            state_nxt    = PRESSED;
            hold_cnt_nxt = '0;
          end else if (hold_cnt == REP_LAST) begin
            tick_nxt     = 1'b1;
            hold_cnt_nxt = '0;
          end else begin
            hold_cnt_nxt = hold_cnt + HOLD_W'(1);
          end
        end
        default: begin
          state_nxt    = RELEASED;
          hold_cnt_nxt = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_debouncer_array.sv
// Array of independent debounced button channels with auto-repeat, plus a
// combined any-button-held flag.
module button_debouncer_array
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS              = DEF_NUM_BUTTONS,
  parameter int DEBOUNCE_WIDTH_IN_CLOCKS = DEF_DEBOUNCE_CLKS,
  parameter int HOLD_DELAY_CLOCKS        = DEF_HOLD_DELAY_CLKS,
  parameter int REPEAT_PERIOD_CLOCKS     = DEF_REPEAT_PERIOD_CLKS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] button,
  input  logic [NUM_BUTTONS-1:0] repeat_en,
  output logic [NUM_BUTTONS-1:0] debounced_button,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] released,
  output logic [NUM_BUTTONS-1:0] repeat_tick,
  output logic                   any_pressed
);

  if (!params_valid(NUM_BUTTONS, DEBOUNCE_WIDTH_IN_CLOCKS, HOLD_DELAY_CLOCKS,
                    REPEAT_PERIOD_CLOCKS)) begin : g_param_check
    $error("button_debouncer_array: all parameters must be >= 1");
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_debouncer_channel #(
      .DEBOUNCE_WIDTH_IN_CLOCKS(DEBOUNCE_WIDTH_IN_CLOCKS),
      .HOLD_DELAY_CLOCKS       (HOLD_DELAY_CLOCKS),
      .REPEAT_PERIOD_CLOCKS    (REPEAT_PERIOD_CLOCKS)
    ) u_ch (
      .clk             (clk),
      .rst             (rst),
      .button          (button[i]),
      .repeat_en       (repeat_en[i]),
      .debounced_button(debounced_button[i]),
      .pressed         (pressed[i]),
      .released        (released[i]),
      .repeat_tick     (repeat_tick[i])
    );
  end

  assign any_pressed = |debounced_button;

endmodule

// File: tb/tb_button_debouncer_array.sv
// Bench for button_debouncer_array: directed scenarios with literal timing
// expectations plus randomized bouncing inputs against an edge-indexed model.
module tb_button_debouncer_array;

  localparam int NB   = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;
  localparam int MAXE = 16384;

  logic          clk, rst;
  logic [NB-1:0] button, repeat_en;
  logic [NB-1:0] debounced_button, pressed, released, repeat_tick;
  logic          any_pressed;

  int tests = 0;
  int fails = 0;
  int ecnt  = 0;

  // Model state: expected outputs after the latest edge
  bit            lvl[NB];
  int            last_clr[NB];
  int            due[NB];
  int            last_rst = 0;
  logic [NB-1:0] m_deb = '0, m_pr = '0, m_rl = '0, m_tk = '0;
  bit            smp[NB][MAXE];
  bit            ss[NB][MAXE];

  button_debouncer_array #(
    .NUM_BUTTONS             (NB),
    .DEBOUNCE_WIDTH_IN_CLOCKS(DEB),
    .HOLD_DELAY_CLOCKS       (HOLD),
    .REPEAT_PERIOD_CLOCKS    (REP)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .button          (button),
    .repeat_en       (repeat_en),
    .debounced_button(debounced_button),
    .pressed         (pressed),
    .released        (released),
    .repeat_tick     (repeat_tick),
    .any_pressed     (any_pressed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", name, ecnt, act, exp);
    end
  endtask

  task automatic steps(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Edge-indexed model: sync seen at edge e is the button sampled at e-2
  // (zero until two edges after reset); the level flips when the DEB edges
  // before it all saw a mismatch with no clear in between. Ticks fall due
  // HOLD edges after the last press or disabled edge, then every REP edges.
  initial begin
    bit sy, tog;
    for (int ch = 0; ch < NB; ch++) begin
      lvl[ch] = 1'b0;
      last_clr[ch] = 0;
      due[ch] = -1;
    end
    forever begin
      @(posedge clk);
      ecnt++;
      if (ecnt >= MAXE) begin
        $display("FAIL edge_budget: got %0d edges, limit %0d", ecnt, MAXE);
        $fatal(1);
      end
      for (int ch = 0; ch < NB; ch++) smp[ch][ecnt] = button[ch];
      if (rst) begin
        last_rst = ecnt;
        m_deb = '0; m_pr = '0; m_rl = '0; m_tk = '0;
        for (int ch = 0; ch < NB; ch++) begin
          lvl[ch] = 1'b0;
          last_clr[ch] = ecnt;
          due[ch] = -1;
          ss[ch][ecnt] = 1'b0;
        end
      end else begin
        for (int ch = 0; ch < NB; ch++) begin
          sy = (ecnt - 2 > last_rst) ? smp[ch][ecnt-2] : 1'b0;
          ss[ch][ecnt] = sy;
          tog = 1'b1;
          for (int k = 1; k <= DEB; k++)
            if ((ecnt - k <= last_clr[ch]) || (ss[ch][ecnt-k] == lvl[ch])) tog = 1'b0;
          m_pr[ch] = 1'b0; m_rl[ch] = 1'b0; m_tk[ch] = 1'b0;
          if (tog) begin
            lvl[ch] = ~lvl[ch];
            last_clr[ch] = ecnt;
            if (lvl[ch]) begin
              m_pr[ch] = 1'b1;
              due[ch] = ecnt + HOLD;
            end else begin
              m_rl[ch] = 1'b1;
              due[ch] = -1;
            end
          end else if (lvl[ch]) begin
            if (!repeat_en[ch]) begin
              due[ch] = ecnt + HOLD;
            end else if (ecnt == due[ch]) begin
              m_tk[ch] = 1'b1;
              due[ch] = ecnt + REP;
            end
          end
          m_deb[ch] = lvl[ch];
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ecnt >= 1)
        chk("model", 32'({debounced_button, pressed, released, repeat_tick, any_pressed}),
            32'({m_deb, m_pr, m_rl, m_tk, |m_deb}));
    end
  end

  // Raises the bits in m and checks the pressed pulse lands 6 edges after
  // the first sampling edge; returns with ecnt at the pulse edge.
  task automatic press_check(input logic [NB-1:0] m, input string nm);
    button = button | m;
    for (int k = 0; k <= 6; k++) begin
      steps(1);
      chk(nm, 32'(pressed), (k == 6) ? 32'(m) : 32'd0);
    end
  endtask

  initial begin
    int p;
    int hold_left[NB];
    rst = 1'b1; button = '0; repeat_en = '0;
    steps(3);
    chk("reset_outputs", 32'({debounced_button, pressed, released, repeat_tick, any_pressed}), 32'd0);
    rst = 1'b0;
    steps(5);

    // Short glitch never reaches the debounced level
    button[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      steps(1);
      chk("glitch_deb", 32'(debounced_button[0]), 32'd0);
    end
    button[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      steps(1);
      chk("glitch_deb", 32'(debounced_button[0]), 32'd0);
      chk("glitch_pressed", 32'(pressed[0]), 32'd0);
    end

    // Press, repeat ticks at 10/13/16/19/22, release lands on a due tick
    repeat_en = 2'b01;
    press_check(2'b01, "press_ch0");
    chk("press_deb", 32'(debounced_button[0]), 32'd1);
    p = ecnt;
    for (int k = 1; k <= 32; k++) begin
      steps(1);
      chk("rep_tick0", 32'(repeat_tick[0]),
          32'(k == 10 || k == 13 || k == 16 || k == 19 || k == 22));
      chk("released0", 32'(released[0]), 32'(k == 25));
      chk("deb0_hold", 32'(debounced_button[0]), 32'(k < 25));
      if (k == 18) button[0] = 1'b0;
    end
    chk("press_offset", 32'(ecnt - p), 32'd32);
    steps(10);

    // Two disabled cycles restart the full hold delay
    press_check(2'b01, "press_ch0_b");
    for (int k = 1; k <= 28; k++) begin
      steps(1);
      chk("en_gap_tick", 32'(repeat_tick[0]), 32'(k == 10 || k == 24 || k == 27));
      if (k == 12) repeat_en[0] = 1'b0;
      if (k == 14) repeat_en[0] = 1'b1;
    end
    button[0] = 1'b0;
    steps(12);

    // Simultaneous press on both channels
    press_check(2'b11, "press_both");
    chk("any_pressed_hi", 32'(any_pressed), 32'd1);
    button = '0;
    steps(12);
    chk("any_pressed_lo", 32'(any_pressed), 32'd0);

    // Channel 1 press does not disturb channel 0 repeat cadence
    press_check(2'b01, "press_ch0_c");
    for (int k = 1; k <= 23; k++) begin
      steps(1);
      chk("indep_tick", 32'(repeat_tick),
          32'({1'b0, (k == 10 || k == 13 || k == 16 || k == 19 || k == 22)}));
      chk("indep_press1", 32'(pressed[1]), 32'(k == 18));
      if (k == 11) button[1] = 1'b1;
    end

    // Reset while repeating with both buttons held
    rst = 1'b1;
    steps(1);
    chk("rst_outputs", 32'({debounced_button, pressed, released, repeat_tick, any_pressed}), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      steps(1);
      chk("post_rst_pressed", 32'(pressed), (k == 7) ? 32'd3 : 32'd0);
      chk("post_rst_deb", 32'(debounced_button), (k == 7) ? 32'd3 : 32'd0);
      chk("post_rst_other", 32'({released, repeat_tick}), 32'd0);
    end
    button = '0; repeat_en = '0;
    steps(12);

    // Randomized bouncing, enable changes and occasional resets
    for (int ch = 0; ch < NB; ch++) hold_left[ch] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (hold_left[ch] == 0) begin
          button[ch] = 1'($urandom_range(0, 1));
          hold_left[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                                      : int'($urandom_range(4, 40));
        end else begin
          hold_left[ch]--;
        end
      end
      if ($urandom_range(0, 39) == 0) repeat_en = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 599) == 0);
      steps(1);
    end
    rst = 1'b0;
    steps(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
